// File: rtl/axi_wr_slave_ram_if.sv
// rtl/axi_wr_slave_ram_if.sv - AXI3 write-channel bundle (AW/W/B) between write buffer and RAM responder
interface axi_wr_slave_ram_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wid, wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_wr_slave_ram.sv
// rtl/axi_wr_slave_ram.sv - single-outstanding AXI3 write responder committing beats to a byte-enabled RAM port
module axi_wr_slave_ram #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rstn,
    axi_wr_slave_ram_if.slave bus,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata
);
    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t            state, state_n;
    logic              rdy;
    logic [3:0]        id_q;
    logic [MEM_AW-1:0] addr_q, addr_n, wmask, addr_inc;
    logic [3:0]        len_q, cnt_q;
    logic [1:0]        burst_q;
    logic              err_hdr_q, err_q;
    logic              aw_hs, beat, burst_end, hdr_err, last_cnt;

    assign aw_hs     = (state == IDLE) && rdy && bus.awvalid;
    assign beat      = (state == DATA) && bus.wvalid;
    assign last_cnt  = (cnt_q == len_q);
    assign burst_end = beat && (bus.wlast || last_cnt);

    assign hdr_err = (bus.awsize != 3'b010) || (bus.awaddr[1:0] != 2'b00) ||
                     (bus.awburst == 2'b11) ||
                     ((bus.awburst == 2'b10) && !(bus.awlen inside {4'd1, 4'd3, 4'd7, 4'd15}));

    // WRAP lengths are 2^k-1, so len itself is the mask of the wrapping address bits
    assign wmask    = MEM_AW'(len_q);
    assign addr_inc = addr_q + MEM_AW'(1);

    always_comb begin
        addr_n = addr_q;
        case (burst_q)
            2'b01:   addr_n = addr_inc;
            2'b10:   addr_n = (addr_q & ~wmask) | (addr_inc & wmask);
            default: addr_n = addr_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (aw_hs) state_n = DATA;
            DATA:    if (burst_end) state_n = RESP;
            RESP:    if (bus.bready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy       <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            burst_q   <= '0;
            err_hdr_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rdy <= 1'b1;
            if (aw_hs) begin
                id_q      <= bus.awid;
                addr_q    <= bus.awaddr[MEM_AW+1:2];
                len_q     <= bus.awlen;
                burst_q   <= bus.awburst;
                cnt_q     <= '0;
                err_hdr_q <= hdr_err;
                err_q     <= 1'b0;
            end else if (beat) begin
                addr_q <= addr_n;
                cnt_q  <= cnt_q + 4'd1;
                if (burst_end) err_q <= err_hdr_q || (bus.wlast != last_cnt);
            end
        end
    end

    always_comb begin
        bus.awready = (state == IDLE) && rdy;
        bus.wready  = (state == DATA);
        bus.bvalid  = (state == RESP);
        bus.bid     = (state == RESP) ? id_q : 4'd0;
        bus.bresp   = ((state == RESP) && err_q) ? 2'b10 : 2'b00;
        mem_we      = (beat && !err_hdr_q) ? bus.wstrb : 4'b0000;
        mem_addr    = beat ? addr_q : '0;
        mem_wdata   = beat ? bus.wdata : 32'd0;
    end
endmodule

// File: doc/axi_wr_slave_ram.md
# axi_wr_slave_ram

AXI3 write-channel responder that terminates the AW/W/B write traffic from the data-cache write buffer (cached line write-back and uncached pass-through) and commits each beat into a word-addressed, byte-enabled memory port. It accepts one burst at a time, supports FIXED/INCR/WRAP bursts of 32-bit beats, checks protocol errors, and returns one B response per burst. It acts as the memory-side model and the on-chip RAM front end for the write path.

## Interface
- MEM_AW, 12, word-address width of the memory port (depth = 2^MEM_AW words)
- clk  in  1  clock
- rstn  in  1  reset; one clock; asynchronous, active-low
- awid  in  4  write ID
- awaddr  in  32  byte start address
- awlen  in  4  beats-1 (1..16 beats)
- awsize  in  3  beat size; only 3'b010 is legal
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- awvalid / awready  in / out  1  AW handshake
- wid  in  4  ignored
- wdata  in  32  beat data
- wstrb  in  4  byte strobes
- wlast  in  1  last beat marker
- wvalid / wready  in / out  1  W handshake
- bid  out  4  echoed awid
- bresp  out  2  00 OKAY, 10 SLVERR
- bvalid / bready  out / in  1  B handshake
- mem_we  out  4  byte write enables (0 = no write)
- mem_addr  out  MEM_AW  word address
- mem_wdata  out  32  write data

## Operation
- States: IDLE, DATA, RESP.
- IDLE: awready=1 (except the first cycle after rstn deasserts, see Timing). On awvalid&awready, latch id, word address awaddr[MEM_AW+1:2], len, burst, beat counter=0; compute err_hdr; go to DATA.
- err_hdr=1 if awsize!=3'b010, awaddr[1:0]!=0, awburst==11, or (awburst==WRAP and awlen not in {1,3,7,15}).
- DATA: wready=1. Each beat (wvalid&wready): mem_addr=current word address, mem_wdata=wdata, mem_we=wstrb if err_hdr=0 else 4'b0000. The beat counter increments.
- Address update after each beat: FIXED unchanged; INCR +1 modulo 2^MEM_AW; WRAP: the low log2(len+1) bits increment and wrap, the upper bits hold.
- Burst end: the first beat where wlast=1 OR counter==len. Set err_last=1 if wlast!=(counter==len), i.e. early or missing wlast. Move to RESP. Beats after a burst end belong to nothing: wready=0 outside DATA.
- RESP: bvalid=1, bid=latched id, bresp=SLVERR if err_hdr|err_last else OKAY. Outputs hold stable until bready. On bvalid&bready go to IDLE.
- Strobes are honoured per byte. A strobe of 0000 on a beat still counts as a beat.
- mem_we=0 in every cycle without a W handshake in DATA.

## Timing
- Reset (rstn low, async): state=IDLE, awready=0, wready=0, bvalid=0, bid=0, bresp=0, mem_we=0, mem_addr=0, mem_wdata=0, all latched fields=0.
- awready goes high on the first clk edge after rstn rises. It is registered via a reset-hold flop, so it is never high during reset.
- AW handshake in cycle T: wready=1 from T+1. awready=0 from T+1 until the state returns to IDLE.
- Memory write is combinational with the W handshake cycle (0 latency). The memory samples on the same clk edge.
- The final beat handshake in cycle T: bvalid=1 in T+1. If bready is held high, the B handshake occurs in T+1 and awready=1 in T+2.
- Minimum burst cost: 1 AW cycle + N beats + 1 B cycle. Zero bubbles between beats when wvalid is held.
- wvalid may arrive before or with the AW handshake. It is not accepted until DATA (wready=0 in IDLE).
- If rstn is asserted mid-burst, all state is dropped immediately. Partial writes already committed remain in memory, and no B response is issued.
- INCR crossing word 2^MEM_AW-1 wraps to 0. This is not an error.

## Test plan
- INCR, awaddr=0x100, awlen=7, wdata=0xA0..0xA7, wstrb=F, wlast on beat 7, bready=1 -> mem words 0x40..0x47 written in 8 consecutive cycles; bvalid 1 cycle after beat 7, bid=awid, bresp=00; awready high 2 cycles after beat 7.
- WRAP, awaddr=0x18, awlen=3 -> mem_addr sequence 6,7,4,5; bresp=00.
- awsize=3'b000 with awlen=0 -> one beat accepted, mem_we=0000, bresp=10.
- INCR awlen=3 with wlast on beat 1 -> 2 beats written (words a, a+1), burst ends, bresp=10, and wready=0 for the following wvalid until the next AW.
- bready held low 5 cycles -> bvalid/bid/bresp stable for 5 cycles; awready=0 throughout; a single B handshake follows.
- rstn pulsed low asynchronously during beat 3 of an 8-beat burst -> all outputs 0 immediately; no bvalid; the next burst after reset completes with OKAY.
